// File: rtl/control_sequencer_pkg.sv
// ============================================================================
// Module  : control_sequencer_pkg
// Brief   : Shared encodings for the RV32I multicycle control sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

    localparam logic [2:0] CTRL_IDLE    = 3'd0;
    localparam logic [2:0] CTRL_FETCH   = 3'd1;
    localparam logic [2:0] CTRL_DECODE  = 3'd2;
    localparam logic [2:0] CTRL_EXECUTE = 3'd3;
    localparam logic [2:0] CTRL_MEM     = 3'd4;
    localparam logic [2:0] CTRL_WB      = 3'd5;
    localparam logic [2:0] CTRL_ERROR   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = CTRL_IDLE,
        ST_FETCH   = CTRL_FETCH,
        ST_DECODE  = CTRL_DECODE,
        ST_EXECUTE = CTRL_EXECUTE,
        ST_MEM     = CTRL_MEM,
        ST_WB      = CTRL_WB,
        ST_ERROR   = CTRL_ERROR
    } ctrl_state_t;

    localparam logic [1:0] WR_OFF  = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    localparam logic [1:0] MEM_ALU = 2'b00;
    localparam logic [1:0] MEM_LD  = 2'b01;
    localparam logic [1:0] MEM_PC4 = 2'b10;

    localparam logic [2:0] DEFAULT = 3'b000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_mem_op(input logic [1:0] mem_we, input logic [1:0] mem_out_sel);
        return (mem_we != WR_OFF) || (mem_out_sel == MEM_LD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_bus_wait_timer.sv
// ============================================================================
// Module  : bus_wait_timer
// Brief   : Wait-cycle counter shared by the fetch and data bus handshakes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(MAX_WAIT));

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module  : control_sequencer
// Brief   : Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning PC and IR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ready,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] Pc,
    input  logic [2:0]  Branch_sel,
    input  logic        Jump_sel,
    input  logic [1:0]  Mem_we,
    input  logic [1:0]  Mem_out_sel,
    input  logic        Wb_en,
    input  logic        Branch_taken,
    input  logic [31:0] Target,
    output logic        Dmem_req,
    output logic [1:0]  Dmem_we,
    input  logic        Dmem_ready,
    output logic        Rf_we,
    output logic        Retire,
    output logic        Halt
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rst_hold;
    logic        timer_clear;
    logic        timer_count;
    logic        timer_expired;
    logic        take_target;

    assign take_target = Jump_sel || ((Branch_sel != DEFAULT) && Branch_taken);

    // rst_hold keeps IDLE for one full cycle after reset release
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            instr    <= NOP_INSTR;
            rst_hold <= 1'b1;
        end else begin
            state    <= next_state;
            rst_hold <= 1'b0;
            if (state == ST_FETCH && Imem_ready) begin
                instr <= Imem_rdata;
            end
            if (state == ST_WB) begin
                pc <= take_target ? Target : pc + 32'd4;
            end
        end
    end

    always_comb begin
        next_state  = state;
        Imem_req    = 1'b0;
        Dmem_req    = 1'b0;
        Dmem_we     = WR_OFF;
        Rf_we       = 1'b0;
        Retire      = 1'b0;
        Halt        = 1'b0;
        timer_clear = 1'b1;
        timer_count = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst_hold) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                Imem_req    = 1'b1;
                timer_clear = 1'b0;
                timer_count = !Imem_ready;
                if (Imem_ready)         next_state = ST_DECODE;
                else if (timer_expired) next_state = ST_ERROR;
            end
            ST_DECODE: begin
                next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                next_state = is_mem_op(Mem_we, Mem_out_sel) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                Dmem_req    = 1'b1;
                Dmem_we     = Mem_we;
                timer_clear = 1'b0;
                timer_count = !Dmem_ready;
                if (Dmem_ready)         next_state = ST_WB;
                else if (timer_expired) next_state = ST_ERROR;
            end
            ST_WB: begin
                Rf_we      = Wb_en;
                Retire     = 1'b1;
                next_state = ST_FETCH;
            end
            ST_ERROR: begin
                Halt = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    bus_wait_timer #(
        .MAX_WAIT (MEM_TIMEOUT)
    ) u_bus_wait_timer (
        .clk      (Clk),
        .rst      (Rst),
        .clear    (timer_clear),
        .count_en (timer_count),
        .expired  (timer_expired)
    );

    assign Imem_addr = pc;
    assign Pc        = pc;
    assign Instr     = instr;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module  : tb_control_sequencer
// Brief   : Self-checking bench for control_sequencer with a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;
    localparam int          TB_TIMEOUT  = 15;

    logic        Clk;
    logic        Rst;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic [31:0] Imem_rdata;
    logic [31:0] Instr;
    logic [31:0] Pc;
    logic [2:0]  Branch_sel;
    logic        Jump_sel;
    logic [1:0]  Mem_we;
    logic [1:0]  Mem_out_sel;
    logic        Wb_en;
    logic        Branch_taken;
    logic [31:0] Target;
    logic        Dmem_req;
    logic [1:0]  Dmem_we;
    logic        Dmem_ready;
    logic        Rf_we;
    logic        Retire;
    logic        Halt;

    int checks = 0;
    int passed = 0;

    // Per-instruction observations filled by exec_instr
    int          o_cycles, o_rf, o_ret, o_dreq;
    logic        o_dwe_ok, o_next_req, o_tmo;
    logic [31:0] o_next_pc, o_next_addr, o_instr;

    control_sequencer #(
        .RESET_PC    (TB_RESET_PC),
        .MEM_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Imem_req     (Imem_req),
        .Imem_addr    (Imem_addr),
        .Imem_ready   (Imem_ready),
        .Imem_rdata   (Imem_rdata),
        .Instr        (Instr),
        .Pc           (Pc),
        .Branch_sel   (Branch_sel),
        .Jump_sel     (Jump_sel),
        .Mem_we       (Mem_we),
        .Mem_out_sel  (Mem_out_sel),
        .Wb_en        (Wb_en),
        .Branch_taken (Branch_taken),
        .Target       (Target),
        .Dmem_req     (Dmem_req),
        .Dmem_we      (Dmem_we),
        .Dmem_ready   (Dmem_ready),
        .Rf_we        (Rf_we),
        .Retire       (Retire),
        .Halt         (Halt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Leaves the bench at a falling edge with the DUT in its first fetch cycle
    task automatic apply_reset();
        Rst = 1'b1; Imem_ready = 1'b0; Dmem_ready = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        step();
        step();
    endtask

    // Plays memory and decoder for one instruction; collects observations only
    task automatic exec_instr(input logic [31:0] rdata, input logic [2:0] br, input logic jmp,
                              input logic [1:0] we, input logic [1:0] osel, input logic wb,
                              input logic taken, input logic [31:0] tgt,
                              input int iwait, input int dwait, input int budget);
        int  iw, dw;
        bit  done;
        Branch_sel = br; Jump_sel = jmp; Mem_we = we; Mem_out_sel = osel;
        Wb_en = wb; Branch_taken = taken; Target = tgt;
        o_cycles = 0; o_rf = 0; o_ret = 0; o_dreq = 0; o_dwe_ok = 1'b1; o_tmo = 1'b0;
        iw = 0; dw = 0; done = 0;
        while (!done) begin
            if (o_cycles >= budget) begin
                o_tmo = 1'b1;
                break;
            end
            o_cycles++;
            if (Imem_req) begin
                Imem_ready = (iw == iwait);
                Imem_rdata = (iw == iwait) ? rdata : 32'hDEAD_BEEF;
                iw++;
            end else begin
                Imem_ready = 1'b0;
            end
            if (Dmem_req) begin
                o_dreq++;
                if (Dmem_we !== we) o_dwe_ok = 1'b0;
                Dmem_ready = (dw == dwait);
                dw++;
            end else begin
                Dmem_ready = 1'b0;
                if (Dmem_we !== WR_OFF) o_dwe_ok = 1'b0;
            end
            if (Rf_we === 1'b1) o_rf++;
            if (Retire === 1'b1) begin
                o_ret++;
                done = 1;
            end
            step();
        end
        Imem_ready = 1'b0; Dmem_ready = 1'b0;
        o_next_pc = Pc; o_next_req = Imem_req; o_next_addr = Imem_addr; o_instr = Instr;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Imem_ready = 1'b0; Dmem_ready = 1'b0;
        Branch_sel = DEFAULT; Jump_sel = 0; Mem_we = WR_OFF; Mem_out_sel = MEM_ALU;
        Wb_en = 1'b1; Branch_taken = 1'b0; Target = 32'h0; Imem_rdata = 32'h0;
        @(posedge Clk);
        @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({Imem_req, Dmem_req, Rf_we, Retire, Halt, Dmem_we} !== 7'b0)
                $display("FAIL reset_strobes cyc%0d got %b expected 0", i, {Imem_req, Dmem_req, Rf_we, Retire, Halt, Dmem_we});
            else passed++;
            checks++;
            if (Pc !== TB_RESET_PC || Instr !== 32'h13)
                $display("FAIL reset_pc_ir got pc=%h ir=%h expected %h/00000013", Pc, Instr, TB_RESET_PC);
            else passed++;
            if (i < 2) step();
        end
        Rst = 1'b0;
        step();
        checks++;
        if (Imem_req !== 1'b0) $display("FAIL release_idle got imem_req=%b expected 0", Imem_req);
        else passed++;
        step();
        checks++;
        if (Imem_req !== 1'b1 || Imem_addr !== TB_RESET_PC)
            $display("FAIL first_fetch got req=%b addr=%h expected 1/%h", Imem_req, Imem_addr, TB_RESET_PC);
        else passed++;
    endtask

    task automatic test_addi();
        exec_instr(32'h0010_0093, DEFAULT, 1'b0, WR_OFF, MEM_ALU, 1'b1, 1'b0, 32'h0, 0, 0, 50);
        checks++;
        if (o_tmo || o_cycles !== 4 || o_rf !== 1 || o_ret !== 1)
            $display("FAIL addi_timing got tmo=%b cyc=%0d rf=%0d ret=%0d expected 0/4/1/1", o_tmo, o_cycles, o_rf, o_ret);
        else passed++;
        checks++;
        if (o_next_pc !== 32'h104 || o_next_req !== 1'b1 || o_next_addr !== 32'h104 || o_instr !== 32'h0010_0093)
            $display("FAIL addi_next got pc=%h req=%b addr=%h ir=%h expected 104/1/104/00100093", o_next_pc, o_next_req, o_next_addr, o_instr);
        else passed++;
    endtask

    task automatic test_load();
        exec_instr(32'h0000_A103, DEFAULT, 1'b0, WR_OFF, MEM_LD, 1'b1, 1'b0, 32'h0, 0, 3, 50);
        checks++;
        if (o_tmo || o_cycles !== 8 || o_dreq !== 4 || o_rf !== 1 || !o_dwe_ok)
            $display("FAIL lw got tmo=%b cyc=%0d dreq=%0d rf=%0d dwe_ok=%b expected 0/8/4/1/1", o_tmo, o_cycles, o_dreq, o_rf, o_dwe_ok);
        else passed++;
        checks++;
        if (o_next_pc !== 32'h108) $display("FAIL lw_pc got %h expected 00000108", o_next_pc);
        else passed++;
    endtask

    task automatic test_store();
        exec_instr(32'h0020_A023, DEFAULT, 1'b0, WR_WORD, MEM_ALU, 1'b0, 1'b0, 32'h0, 1, 0, 50);
        checks++;
        if (o_tmo || o_cycles !== 6 || o_dreq !== 1 || o_rf !== 0 || !o_dwe_ok)
            $display("FAIL sw got tmo=%b cyc=%0d dreq=%0d rf=%0d dwe_ok=%b expected 0/6/1/0/1", o_tmo, o_cycles, o_dreq, o_rf, o_dwe_ok);
        else passed++;
        checks++;
        if (o_next_pc !== 32'h10C) $display("FAIL sw_pc got %h expected 0000010c", o_next_pc);
        else passed++;
    endtask

    task automatic test_branch_jump();
        exec_instr(32'h0020_8063, 3'b001, 1'b0, WR_OFF, MEM_ALU, 1'b0, 1'b1, 32'h80, 0, 0, 50);
        checks++;
        if (o_tmo || o_next_pc !== 32'h80) $display("FAIL beq_taken got %h expected 00000080", o_next_pc);
        else passed++;
        exec_instr(32'h0020_8063, 3'b001, 1'b0, WR_OFF, MEM_ALU, 1'b0, 1'b0, 32'h80, 0, 0, 50);
        checks++;
        if (o_tmo || o_next_pc !== 32'h84) $display("FAIL beq_not_taken got %h expected 00000084", o_next_pc);
        else passed++;
        exec_instr(32'h0000_00EF, DEFAULT, 1'b1, WR_OFF, MEM_PC4, 1'b1, 1'b0, 32'h80, 0, 0, 50);
        checks++;
        if (o_tmo || o_next_pc !== 32'h80 || o_rf !== 1) $display("FAIL jal got pc=%h rf=%0d expected 00000080/1", o_next_pc, o_rf);
        else passed++;
        exec_instr(32'h0000_00EF, DEFAULT, 1'b1, WR_OFF, MEM_PC4, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0, 50);
        exec_instr(32'h0000_0013, DEFAULT, 1'b0, WR_OFF, MEM_ALU, 1'b1, 1'b1, 32'h80, 0, 0, 50);
        checks++;
        if (o_tmo || o_next_pc !== 32'h0 || o_next_addr !== 32'h0) $display("FAIL pc_wrap got pc=%h addr=%h expected 0/0", o_next_pc, o_next_addr);
        else passed++;
    endtask

    // Ready arriving in the same cycle the counter reaches the limit must advance
    task automatic test_wait_boundary();
        exec_instr(32'h0000_A103, DEFAULT, 1'b0, WR_OFF, MEM_LD, 1'b1, 1'b0, 32'h0, TB_TIMEOUT, TB_TIMEOUT, 100);
        checks++;
        if (o_tmo || Halt !== 1'b0 || o_cycles !== 5 + 2 * TB_TIMEOUT || o_ret !== 1)
            $display("FAIL wait_boundary got tmo=%b halt=%b cyc=%0d ret=%0d expected 0/0/%0d/1", o_tmo, Halt, o_cycles, o_ret, 5 + 2 * TB_TIMEOUT);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, tgt;
        logic [2:0]  br;
        logic [1:0]  we, osel;
        logic        jmp, wb, taken, is_mem, redirect;
        int          cls, iwait, dwait, exp_cyc, exp_rf;
        apply_reset();
        exp_pc = TB_RESET_PC;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 5); iwait = $urandom_range(0, 4); dwait = $urandom_range(0, 4);
            tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            taken = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
            br = DEFAULT; jmp = 1'b0; we = WR_OFF; osel = MEM_ALU;
            is_mem = 1'b0; redirect = 1'b0;
            case (cls)
                1: begin osel = MEM_LD; is_mem = 1'b1; end
                2: begin we = 2'($urandom_range(1, 3)); wb = 1'b0; is_mem = 1'b1; end
                3: begin br = 3'($urandom_range(1, 6)); wb = 1'b0; redirect = taken; end
                4: begin jmp = 1'b1; osel = MEM_PC4; redirect = 1'b1; end
                5: wb = 1'b0;
                default: ;
            endcase
            exp_cyc = 4 + iwait + (is_mem ? 1 + dwait : 0);
            exp_rf  = wb ? 1 : 0;
            exec_instr($urandom, br, jmp, we, osel, wb, taken, tgt, iwait, dwait, 60);
            exp_pc = redirect ? tgt : exp_pc + 32'd4;
            checks++;
            if (o_tmo || o_cycles !== exp_cyc || o_ret !== 1 || o_rf !== exp_rf)
                $display("FAIL rand%0d_timing cls=%0d got tmo=%b cyc=%0d ret=%0d rf=%0d expected 0/%0d/1/%0d", n, cls, o_tmo, o_cycles, o_ret, o_rf, exp_cyc, exp_rf);
            else passed++;
            checks++;
            if (o_dreq !== (is_mem ? dwait + 1 : 0) || !o_dwe_ok)
                $display("FAIL rand%0d_dmem cls=%0d got dreq=%0d dwe_ok=%b expected %0d/1", n, cls, o_dreq, o_dwe_ok, is_mem ? dwait + 1 : 0);
            else passed++;
            checks++;
            if (o_next_pc !== exp_pc || o_next_addr !== exp_pc || o_next_req !== 1'b1)
                $display("FAIL rand%0d_pc cls=%0d got pc=%h addr=%h req=%b expected %h/%h/1", n, cls, o_next_pc, o_next_addr, o_next_req, exp_pc, exp_pc);
            else passed++;
        end
    endtask

    task automatic test_imem_timeout();
        int req_cyc;
        apply_reset();
        req_cyc = 0;
        while (Halt !== 1'b1 && req_cyc < 40) begin
            if (Imem_req) req_cyc++;
            step();
        end
        checks++;
        if (req_cyc !== TB_TIMEOUT + 1 || Halt !== 1'b1 || Imem_req !== 1'b0)
            $display("FAIL imem_timeout got req_cycles=%0d halt=%b req=%b expected %0d/1/0", req_cyc, Halt, Imem_req, TB_TIMEOUT + 1);
        else passed++;
        Imem_ready = 1'b1; Dmem_ready = 1'b1;
        repeat (5) step();
        checks++;
        if (Halt !== 1'b1 || Imem_req !== 1'b0 || Retire !== 1'b0 || Pc !== TB_RESET_PC || Instr !== 32'h13)
            $display("FAIL halt_sticky got halt=%b req=%b ret=%b pc=%h ir=%h expected 1/0/0/%h/00000013", Halt, Imem_req, Retire, Pc, Instr, TB_RESET_PC);
        else passed++;
        Imem_ready = 1'b0; Dmem_ready = 1'b0;
        Rst = 1'b1;
        step();
        checks++;
        if (Halt !== 1'b0 || Imem_req !== 1'b0) $display("FAIL halt_clear got halt=%b req=%b expected 0/0", Halt, Imem_req);
        else passed++;
        Rst = 1'b0;
        step();
        step();
        checks++;
        if (Imem_req !== 1'b1 || Imem_addr !== TB_RESET_PC) $display("FAIL post_halt_fetch got req=%b addr=%h expected 1/%h", Imem_req, Imem_addr, TB_RESET_PC);
        else passed++;
    endtask

    task automatic test_dmem_timeout();
        apply_reset();
        exec_instr(32'h0020_A023, DEFAULT, 1'b0, WR_WORD, MEM_ALU, 1'b0, 1'b0, 32'h0, 0, 1000, 60);
        checks++;
        if (o_tmo !== 1'b1 || Halt !== 1'b1 || o_dreq !== TB_TIMEOUT + 1 || o_ret !== 0 || o_next_pc !== TB_RESET_PC)
            $display("FAIL dmem_timeout got tmo=%b halt=%b dreq=%0d ret=%0d pc=%h expected 1/1/%0d/0/%h", o_tmo, Halt, o_dreq, o_ret, o_next_pc, TB_TIMEOUT + 1, TB_RESET_PC);
        else passed++;
        checks++;
        if (Dmem_req !== 1'b0 || Dmem_we !== WR_OFF) $display("FAIL dmem_err_strobes got req=%b we=%b expected 0/00", Dmem_req, Dmem_we);
        else passed++;
    endtask

    task automatic test_reset_midop();
        int stray;
        apply_reset();
        Branch_sel = DEFAULT; Jump_sel = 1'b0; Mem_we = WR_OFF; Mem_out_sel = MEM_LD; Wb_en = 1'b1;
        Imem_ready = 1'b1; Imem_rdata = 32'h0000_A103;
        step();
        Imem_ready = 1'b0;
        step();
        step();
        checks++;
        if (Dmem_req !== 1'b1) $display("FAIL midop_in_mem got dmem_req=%b expected 1", Dmem_req);
        else passed++;
        Rst = 1'b1;
        step();
        checks++;
        if (Dmem_req !== 1'b0 || Imem_req !== 1'b0 || Retire !== 1'b0 || Rf_we !== 1'b0 || Pc !== TB_RESET_PC)
            $display("FAIL midop_abort got dreq=%b ireq=%b ret=%b rf=%b pc=%h expected 0/0/0/0/%h", Dmem_req, Imem_req, Retire, Rf_we, Pc, TB_RESET_PC);
        else passed++;
        Rst = 1'b0; Dmem_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            if (Retire === 1'b1 || Rf_we === 1'b1) stray++;
            step();
        end
        Dmem_ready = 1'b0;
        checks++;
        if (stray !== 0) $display("FAIL midop_no_retire got %0d strobes expected 0", stray);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_branch_jump();
        test_wait_boundary();
        test_random();
        test_imem_timeout();
        test_dmem_timeout();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
